score_board_mux: RTL

- Parametrised successor to the fixed 4-digit game scoreboard.
- Counts `get` and `lose` events coming from the VGA game logic into an N-digit saturating BCD score and a lives counter.
- Runs a PLAY/OVER state machine.
- Time-multiplexes the score onto a common-anode seven-segment display with a configurable digit count and scan rate.

---
 rtl/score_pkg.sv | 22 ++
 rtl/seg7_decode.sv | 27 ++
 rtl/score_board_mux.sv | 134 +++++++++++++
 3 files changed

// File: rtl/score_pkg.sv
// rtl/score_pkg.sv - shared state type and active-low segment glyphs for the scoreboard
package score_pkg;

  typedef enum logic {
    PLAY = 1'b0,
    OVER = 1'b1
  } state_t;

  // Active-low glyphs, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_ZERO  = 7'h40;
  localparam logic [6:0] SEG_ONE   = 7'h79;
  localparam logic [6:0] SEG_TWO   = 7'h24;
  localparam logic [6:0] SEG_THREE = 7'h30;
  localparam logic [6:0] SEG_FOUR  = 7'h19;
  localparam logic [6:0] SEG_FIVE  = 7'h12;
  localparam logic [6:0] SEG_SIX   = 7'h02;
  localparam logic [6:0] SEG_SEVEN = 7'h78;
  localparam logic [6:0] SEG_EIGHT = 7'h00;
  localparam logic [6:0] SEG_NINE  = 7'h10;

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - combinational BCD digit to active-low seven-segment pattern
module seg7_decode
  import score_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  // Non-BCD codes fall through to a blank digit
  always_comb begin
    seg = SEG_BLANK;
    case (digit)
      4'd0: seg = SEG_ZERO;
      4'd1: seg = SEG_ONE;
      4'd2: seg = SEG_TWO;
      4'd3: seg = SEG_THREE;
      4'd4: seg = SEG_FOUR;
      4'd5: seg = SEG_FIVE;
      4'd6: seg = SEG_SIX;
      4'd7: seg = SEG_SEVEN;
      4'd8: seg = SEG_EIGHT;
      4'd9: seg = SEG_NINE;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/score_board_mux.sv
// rtl/score_board_mux.sv - N-digit saturating BCD scoreboard with lives, PLAY/OVER FSM and muxed display (option: SCORE_BOARD_ZERO_BLANK_EN)
module score_board_mux
  import score_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int LIVES      = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    get,
  input  logic                    lose,
  input  logic                    restart,
  output logic [4*NUM_DIGITS-1:0] score_bcd,
  output logic [3:0]              lives,
  output logic                    game_over,
  output logic [NUM_DIGITS-1:0]   select,
  output logic [6:0]              seg
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(NUM_DIGITS);

  state_t                  state;
  logic                    get_d, lose_d;
  logic                    get_rise, lose_rise;
  logic [CW-1:0]           scan_cnt;
  logic [IW-1:0]           idx, idx_nxt;
  logic [4*NUM_DIGITS-1:0] score_inc;
  logic                    carry;
  logic                    all_nines;
  logic [3:0]              cur_digit;
  logic [6:0]              seg_dec, seg_nxt;

  assign get_rise  = get & ~get_d;
  assign lose_rise = lose & ~lose_d;

  // Ripple BCD increment; an all-9s score is held rather than wrapped
  always_comb begin
    score_inc = score_bcd;
    carry     = 1'b1;
    all_nines = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (score_bcd[4*k +: 4] != 4'd9) all_nines = 1'b0;
      if (carry) begin
        if (score_bcd[4*k +: 4] == 4'd9) begin
          score_inc[4*k +: 4] = 4'd0;
        end else begin
          score_inc[4*k +: 4] = score_bcd[4*k +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
    if (all_nines) score_inc = score_bcd;
  end

  // Digit index that select/seg will show after this edge, so both move together
  always_comb begin
    idx_nxt = idx;
    if (scan_cnt == CW'(SCAN_DIV - 1)) begin
      idx_nxt = (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
    end
  end

  assign cur_digit = score_bcd[{idx_nxt, 2'b00} +: 4];

  seg7_decode u_seg7_decode (
    .digit (cur_digit),
    .seg   (seg_dec)
  );

`ifdef SCORE_BOARD_ZERO_BLANK_EN
  logic lead_zero;

  // Blank a digit when it and everything more significant is zero; digit 0 always shows
  always_comb begin
    lead_zero = (idx_nxt != '0);
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if ((IW'(k) >= idx_nxt) && (score_bcd[4*k +: 4] != 4'd0)) lead_zero = 1'b0;
    end
    seg_nxt = lead_zero ? SEG_BLANK : seg_dec;
  end
`else
  assign seg_nxt = seg_dec;
`endif

  // Edge history, game FSM, score/lives and display scan
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      get_d     <= 1'b0;
      lose_d    <= 1'b0;
      state     <= PLAY;
      score_bcd <= '0;
      lives     <= 4'(LIVES);
      game_over <= 1'b0;
      scan_cnt  <= '0;
      idx       <= '0;
      select    <= ~NUM_DIGITS'(1);
      seg       <= SEG_ZERO;
    end else begin
      get_d  <= get;
      lose_d <= lose;

      case (state)
        PLAY: begin
          if (lose_rise) begin
            lives <= lives - 4'd1;
            if (lives == 4'd1) begin
              state     <= OVER;
              game_over <= 1'b1;
            end
          end else if (get_rise) begin
            score_bcd <= score_inc;
          end
        end
        OVER: begin
          if (restart) begin
            state     <= PLAY;
            game_over <= 1'b0;
            score_bcd <= '0;
            lives     <= 4'(LIVES);
          end
        end
        default: state <= PLAY;
      endcase

      scan_cnt <= (scan_cnt == CW'(SCAN_DIV - 1)) ? '0 : scan_cnt + 1'b1;
      idx      <= idx_nxt;
      select   <= ~(NUM_DIGITS'(1) << idx_nxt);
      seg      <= seg_nxt;
    end
  end

endmodule
